// File: rtl/tms9919_pkg.sv
// Shared definitions for the TMS9919 command writer.
// Contents: request kind codes, register-select codes ({chan, att_flag}),
// latch-byte constants, writer FSM state type, latch-byte helper.
package tms9919_pkg;

  localparam logic KIND_PERIOD = 1'b0;
  localparam logic KIND_ATT    = 1'b1;

  // Register-select codes, formed as {chan[1:0], att_flag}
  localparam logic [2:0] SEL_TONE0 = 3'd0;
  localparam logic [2:0] SEL_ATT0  = 3'd1;
  localparam logic [2:0] SEL_TONE1 = 3'd2;
  localparam logic [2:0] SEL_ATT1  = 3'd3;
  localparam logic [2:0] SEL_TONE2 = 3'd4;
  localparam logic [2:0] SEL_ATT2  = 3'd5;
  localparam logic [2:0] SEL_NOISE = 3'd6;
  localparam logic [2:0] SEL_ATT3  = 3'd7;

  localparam logic       LATCH_MSB   = 1'b1;
  localparam logic [3:0] NOISE_LATCH = {LATCH_MSB, SEL_NOISE};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2
  } state_t;

  function automatic logic [7:0] latch_byte(input logic [2:0] sel, input logic [3:0] data);
    return {LATCH_MSB, sel, data};
  endfunction

endpackage

// File: rtl/tms9919_gap_timer.sv
// Minimum-gap timer between write strobes.
// Ports: clk, reset (async, active-high), i_load (reload with GAP-1),
//        o_zero (timer has expired; a strobe may be issued).
module tms9919_gap_timer #(
  parameter int GAP = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_zero
);

  localparam logic [7:0] LOAD_VAL = 8'(GAP - 1);

  logic [7:0] r_cnt;

  // Down-counter that parks at zero until the next strobe reloads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_cnt <= 8'd0;
    else if (i_load)          r_cnt <= LOAD_VAL;
    else if (r_cnt != 8'd0)   r_cnt <= r_cnt - 8'd1;
  end

  assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/tms9919_writer.sv
// Serialises tone-period / noise / attenuation updates into TMS9919 byte
// writes, pacing we strobes by GAP clocks and suppressing redundant bytes
// using a shadow copy of every sound register.
// Ports: clk, reset (async, active-high); req_valid/req_ready handshake with
//        req_chan, req_kind, req_value; we/data_out to the sound block;
//        skip_count counts fully suppressed requests (wraps).
//
// state    | meaning
// ST_IDLE  | ready for a request; skipped requests complete here
// ST_EMIT1 | waiting for gap expiry, then strobes the latch byte
// ST_EMIT2 | waiting for gap expiry, then strobes the period high byte
module tms9919_writer
  import tms9919_pkg::*;
#(
  parameter int GAP            = 32,
  parameter bit SKIP_REDUNDANT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_chan,
  input  logic       req_kind,
  input  logic [9:0] req_value,
  output logic       we,
  output logic [7:0] data_out,
  output logic [7:0] skip_count
);

  state_t     r_state, w_state_nxt;
  logic       w_zero, w_accept, w_skip_inc, w_strobe, w_sel2, w_last;
  logic       w_full_hit, w_hi_hit, w_is_tone, w_skip, w_two;
  logic [7:0] w_byte1;

  logic [1:0] r_chan;
  logic       r_kind;
  logic [9:0] r_value;
  logic       r_two;
  logic       r_we;
  logic [7:0] r_data, r_skip_cnt;

  logic [9:0] r_per [3];
  logic [2:0] r_per_vld;
  logic [3:0] r_att [4];
  logic [3:0] r_att_vld;
  logic [2:0] r_noise;
  logic       r_noise_vld;

  tms9919_gap_timer #(.GAP(GAP)) u_gap (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_strobe),
    .o_zero (w_zero)
  );

  // Shadow lookup against the incoming request (only the bits the chip uses).
  always_comb begin
    w_full_hit = 1'b0;
    w_hi_hit   = 1'b0;
    case ({req_chan, req_kind})
      SEL_TONE0, SEL_TONE1, SEL_TONE2: begin
        for (int i = 0; i < 3; i++) begin
          if (req_chan == 2'(i)) begin
            w_full_hit = r_per_vld[i] && (r_per[i] == req_value);
            w_hi_hit   = r_per_vld[i] && (r_per[i][9:4] == req_value[9:4]);
          end
        end
      end
      SEL_NOISE:
        w_full_hit = r_noise_vld && (r_noise == req_value[2:0]);
      SEL_ATT0, SEL_ATT1, SEL_ATT2, SEL_ATT3:
        w_full_hit = r_att_vld[req_chan] && (r_att[req_chan] == req_value[3:0]);
      default: ;
    endcase
  end

  assign w_is_tone = (req_kind == KIND_PERIOD) && (req_chan != 2'd3);
  assign w_skip    = SKIP_REDUNDANT && w_full_hit;
  // A matching high field means the chip already holds it; latch byte alone suffices.
  assign w_two     = w_is_tone && !(SKIP_REDUNDANT && w_hi_hit);

  assign w_byte1 = ((r_chan == 2'd3) && (r_kind == KIND_PERIOD))
                   ? {NOISE_LATCH, r_value[3:0]}
                   : latch_byte({r_chan, r_kind}, r_value[3:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_skip_inc  = 1'b0;
    w_strobe    = 1'b0;
    w_sel2      = 1'b0;
    w_last      = 1'b0;
    req_ready   = (r_state == ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_skip) begin
            w_skip_inc = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_EMIT1;
          end
        end
      end
      ST_EMIT1: begin
        if (w_zero) begin
          w_strobe = 1'b1;
          if (r_two) begin
            w_state_nxt = ST_EMIT2;
          end else begin
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_EMIT2: begin
        if (w_zero) begin
          w_strobe    = 1'b1;
          w_sel2      = 1'b1;
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_data      <= 8'h00;
      r_skip_cnt  <= 8'h00;
      r_chan      <= 2'd0;
      r_kind      <= 1'b0;
      r_value     <= 10'd0;
      r_two       <= 1'b0;
      r_per_vld   <= 3'b000;
      r_att_vld   <= 4'b0000;
      r_noise     <= 3'd0;
      r_noise_vld <= 1'b0;
      for (int i = 0; i < 3; i++) r_per[i] <= 10'd0;
      for (int i = 0; i < 4; i++) r_att[i] <= 4'd0;
    end else begin
      r_we <= w_strobe;
      if (w_strobe) r_data <= w_sel2 ? {2'b00, r_value[9:4]} : w_byte1;
      if (w_accept) begin
        r_chan  <= req_chan;
        r_kind  <= req_kind;
        r_value <= req_value;
        r_two   <= w_two;
      end
      if (w_skip_inc) r_skip_cnt <= r_skip_cnt + 8'd1;
      // Shadow follows the chip: commit once the final byte is on the bus.
      if (w_last) begin
        if (r_kind == KIND_ATT) begin
          r_att[r_chan]     <= r_value[3:0];
          r_att_vld[r_chan] <= 1'b1;
        end else if (r_chan == 2'd3) begin
          r_noise     <= r_value[2:0];
          r_noise_vld <= 1'b1;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (r_chan == 2'(i)) begin
              r_per[i]     <= r_value;
              r_per_vld[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign we         = r_we;
  assign data_out   = r_data;
  assign skip_count = r_skip_cnt;

endmodule

// File: tb/tb_tms9919_writer.sv
// Scoreboard bench for tms9919_writer: dut0 (GAP=4, suppression on) and
// dut1 (GAP=4, suppression off). Drivers push expected bytes with their
// expected strobe edge; per-DUT monitors pop and compare on every we.
module tb_tms9919_writer;

  localparam int GAP = 4;

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic       valid0, valid1, ready0, ready1;
  logic [1:0] chan0, chan1;
  logic       kind0, kind1;
  logic [9:0] value0, value1;
  logic       we0, we1;
  logic [7:0] data0, data1, skip0, skip1;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_s[2];
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tms9919_writer #(.GAP(GAP), .SKIP_REDUNDANT(1'b1)) dut0 (
    .clk(clk), .reset(rst0), .req_valid(valid0), .req_ready(ready0),
    .req_chan(chan0), .req_kind(kind0), .req_value(value0),
    .we(we0), .data_out(data0), .skip_count(skip0)
  );

  tms9919_writer #(.GAP(GAP), .SKIP_REDUNDANT(1'b0)) dut1 (
    .clk(clk), .reset(rst1), .req_valid(valid1), .req_ready(ready1),
    .req_chan(chan1), .req_kind(kind1), .req_value(value1),
    .we(we1), .data_out(data1), .skip_count(skip1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [1:0] ch, input logic k,
                       input logic [9:0] val);
    if (d == 0) begin valid0 = v; chan0 = ch; kind0 = k; value0 = val; end
    else        begin valid1 = v; chan1 = ch; kind1 = k; value1 = val; end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? ready0 : ready1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Expected strobe edge: one after acceptance, but never closer than GAP to the previous strobe.
  task automatic push(input int d, input logic [7:0] b, input int acc);
    exp_t e;
    int   t;
    t = (acc + 1 > last_s[d] + GAP) ? acc + 1 : last_s[d] + GAP;
    last_s[d] = t;
    e.b   = b;
    e.cyc = t;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic send(input int d, input logic [1:0] ch, input logic k, input logic [9:0] v,
                      input int nbytes, input logic [7:0] b1, input logic [7:0] b2,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    drive(d, 1'b1, ch, k, v);
    while (!rdy(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout dut%0d: ready stayed 0, expected 1", d);
      drive(d, 1'b0, 2'd0, 1'b0, 10'd0);
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    drive(d, 1'b0, 2'd0, 1'b0, 10'd0);
    if (nbytes > 0) push(d, b1, acc);
    if (nbytes > 1) push(d, b2, acc);
  endtask

  task automatic goto_edge(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("drain_dut%0d_pending", d), qsize(d), 0);
    repeat (GAP + 2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (we0) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut0_unexpected_we: got data 0x%02h at edge %0d, expected no strobe", data0, cyc);
      end else begin
        e0 = q0.pop_front();
        check("dut0_byte", data0, e0.b);
        check("dut0_strobe_edge", cyc, e0.cyc);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (we1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut1_unexpected_we: got data 0x%02h at edge %0d, expected no strobe", data1, cyc);
      end else begin
        e1 = q1.pop_front();
        check("dut1_byte", data1, e1.b);
        check("dut1_strobe_edge", cyc, e1.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a;
    last_s[0] = -100;
    last_s[1] = -100;
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, 2'd0, 1'b0, 10'd0);
    drive(1, 1'b0, 2'd0, 1'b0, 10'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_we0", we0, 0);
    check("rst_data0", data0, 0);
    check("rst_skip0", skip0, 0);
    check("rst_we1", we1, 0);
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    check("ready0_after_release", ready0, 1);
    check("ready1_after_release", ready1, 1);

    // chan1 period 0x2A5: latch 0xA5 at A+1, high 0x2A at A+5
    send(0, 2'd1, 1'b0, 10'h2A5, 2, 8'hA5, 8'h2A, a);
    goto_edge(a + 4);
    check("t1_ready_busy", ready0, 0);
    goto_edge(a + 5);
    check("t1_ready_back", ready0, 1);
    drain(0);

    // identical request is fully suppressed
    send(0, 2'd1, 1'b0, 10'h2A5, 0, 8'h00, 8'h00, a);
    goto_edge(a + 1);
    check("t2_ready_after_skip", ready0, 1);
    check("t2_skip_count", skip0, 1);

    // same high field: latch byte only
    send(0, 2'd1, 1'b0, 10'h2A7, 1, 8'hA7, 8'h00, a);
    drain(0);

    // attenuation then noise back-to-back, paced 4 cycles apart
    send(0, 2'd2, 1'b1, 10'h009, 1, 8'hD9, 8'h00, a);
    send(0, 2'd3, 1'b0, 10'h005, 1, 8'hE5, 8'h00, a);
    drain(0);
    check("t3_skip_unchanged", skip0, 1);

    // suppression disabled: duplicates are re-sent
    send(1, 2'd0, 1'b1, 10'h00F, 1, 8'h9F, 8'h00, a);
    send(1, 2'd0, 1'b1, 10'h00F, 1, 8'h9F, 8'h00, a);
    drain(1);
    check("t4_skip1_zero", skip1, 0);

    // reset between the two bytes of a period write drops the second byte
    send(0, 2'd0, 1'b0, 10'h3FF, 1, 8'h8F, 8'h00, a);
    goto_edge(a + 2);
    rst0 = 1'b1;
    #1;
    check("t5_rst_we", we0, 0);
    check("t5_rst_data", data0, 0);
    check("t5_rst_skip", skip0, 0);
    check("t5_rst_ready", ready0, 1);
    goto_edge(a + 4);
    rst0 = 1'b0;
    last_s[0] = -100;
    goto_edge(a + 5);
    check("t5_ready_after_release", ready0, 1);
    repeat (GAP + 2) @(posedge clk);
    #1;
    send(0, 2'd0, 1'b0, 10'h3FF, 2, 8'h8F, 8'h3F, a);
    drain(0);

    // 300 suppressed requests wrap the counter to 44
    for (int i = 0; i < 300; i++) send(0, 2'd0, 1'b0, 10'h3FF, 0, 8'h00, 8'h00, a);
    goto_edge(a + 1);
    check("t6_skip_wrap", skip0, 44);
    check("t6_ready", ready0, 1);
    repeat (GAP + 2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
